// File: rtl/cu_ext_pkg.sv
// Shared encodings for the second-generation accumulator control unit:
// opcodes, FSM state codes, ALU/accumulator-mux codes and decode classes.
package cu_ext_pkg;

  // Opcodes; anything with a bit above bit 3 set is illegal as well
  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_IN    = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JPOS  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_JNEG  = 4'd13;
  localparam logic [3:0] OP_NOP   = 4'd14;

  // FSM state codes, visible on the debug port
  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEMOP  = 3'd3,
    S_EXEC   = 3'd4,
    S_INPUT  = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // ALU function codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;
  localparam logic [2:0] ALU_SHR  = 3'b110;

  // Accumulator source select
  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Which state an opcode is routed to after DECODE
  typedef enum logic [2:0] {
    CLS_MEM   = 3'd0,
    CLS_INPUT = 3'd1,
    CLS_EXEC  = 3'd2,
    CLS_HALT  = 3'd3,
    CLS_ILL   = 3'd4
  } op_class_t;

  // Branch condition selector for the jump opcodes
  typedef enum logic [2:0] {
    JC_NONE   = 3'd0,
    JC_ZERO   = 3'd1,
    JC_POS    = 3'd2,
    JC_ALWAYS = 3'd3,
    JC_NEG    = 3'd4
  } jcond_t;

  // Resolve a branch condition against the accumulator status flags;
  // "negative" means neither zero nor positive
  function automatic logic jump_taken(input jcond_t jc, input logic aeq0, input logic apos);
    case (jc)
      JC_ZERO:   return aeq0;
      JC_POS:    return apos;
      JC_ALWAYS: return 1'b1;
      JC_NEG:    return !aeq0 && !apos;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_ext_decode.sv
// Combinational opcode decoder shared by the DECODE, MEMOP and EXEC logic.
module cu_ext_decode
  import cu_ext_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] ir,
  output op_class_t       op_class,
  output logic [2:0]      alu_op,
  output logic [1:0]      asel,
  output logic            is_store,
  output jcond_t          jcond,
  output logic            illegal
);

  logic       upper_set;
  logic [3:0] low_op;

  assign upper_set = (ir >> 4) != '0;
  assign low_op    = ir[3:0];

  // Map the opcode onto its routing class and datapath control fields
  always_comb begin
    op_class = CLS_ILL;
    alu_op   = ALU_PASS;
    asel     = ASEL_ALU;
    is_store = 1'b0;
    jcond    = JC_NONE;
    illegal  = 1'b0;
    if (upper_set) begin
      illegal = 1'b1;
    end else begin
      case (low_op)
        OP_LOAD:  begin op_class = CLS_MEM;  asel = ASEL_MEM; end
        OP_STORE: begin op_class = CLS_MEM;  is_store = 1'b1; end
        OP_ADD:   begin op_class = CLS_MEM;  alu_op = ALU_ADD; end
        OP_SUB:   begin op_class = CLS_MEM;  alu_op = ALU_SUB; end
        OP_AND:   begin op_class = CLS_MEM;  alu_op = ALU_AND; end
        OP_OR:    begin op_class = CLS_MEM;  alu_op = ALU_OR;  end
        OP_IN:    begin op_class = CLS_INPUT; asel = ASEL_IN;  end
        OP_JZ:    begin op_class = CLS_EXEC; jcond = JC_ZERO;   end
        OP_JPOS:  begin op_class = CLS_EXEC; jcond = JC_POS;    end
        OP_JMP:   begin op_class = CLS_EXEC; jcond = JC_ALWAYS; end
        OP_JNEG:  begin op_class = CLS_EXEC; jcond = JC_NEG;    end
        OP_SHL:   begin op_class = CLS_EXEC; alu_op = ALU_SHL;  end
        OP_SHR:   begin op_class = CLS_EXEC; alu_op = ALU_SHR;  end
        OP_NOP:   begin op_class = CLS_EXEC; end
        OP_HALT:  begin op_class = CLS_HALT; end
        default:  begin illegal = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/cu_ext.sv
// Second-generation control unit for the accumulator processor: fetch/decode/
// execute FSM with a memory request/ready handshake and a timeout watchdog.
module cu_ext
  import cu_ext_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enter,
  input  logic            aeq0,
  input  logic            apos,
  input  logic [OP_W-1:0] ir,
  input  logic            mem_ready,
  input  logic            resume,
  output logic            ir_load,
  output logic            pc_load,
  output logic            jmp_mux,
  output logic            mem_inst,
  output logic            mem_wr,
  output logic            mem_req,
  output logic            aload,
  output logic [1:0]      asel,
  output logic [2:0]      alu_op,
  output logic            halt,
  output logic            err,
  output logic [2:0]      state
);

  // A disabled watchdog still keeps a one-bit counter so the width is legal
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] wd_cnt;
  logic             waiting;
  logic             timeout;

  op_class_t dec_class;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_asel;
  logic       dec_store;
  jcond_t     dec_jcond;
  logic       dec_illegal;

  cu_ext_decode #(.OP_W(OP_W)) u_decode (
    .ir       (ir),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .asel     (dec_asel),
    .is_store (dec_store),
    .jcond    (dec_jcond),
    .illegal  (dec_illegal)
  );

  assign state   = state_q;
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMOP);

  // The watchdog fires on the cycle whose increment would make the counter
  // reach MEM_TIMEOUT, so memory gets exactly MEM_TIMEOUT unanswered cycles
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready &&
                   ((int'(wd_cnt) + 1) == MEM_TIMEOUT);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_START;
    else        state_q <= state_n;
  end

  // Watchdog counter: counts unanswered handshake cycles, clears otherwise
  always_ff @(posedge clk) begin
    if (!reset)                                       wd_cnt <= '0;
    else if (MEM_TIMEOUT == 0 || !waiting || mem_ready) wd_cnt <= '0;
    else                                              wd_cnt <= wd_cnt + 1'b1;
  end

  // Next-state and combinational output decode
  always_comb begin
    state_n  = state_q;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    jmp_mux  = 1'b0;
    mem_inst = 1'b0;
    mem_wr   = 1'b0;
    mem_req  = 1'b0;
    aload    = 1'b0;
    asel     = ASEL_ALU;
    alu_op   = ALU_PASS;
    halt     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_START: state_n = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          state_n = S_DECODE;
        end else if (timeout) begin
          state_n = S_ERR;
        end
      end
      S_DECODE: begin
        mem_inst = 1'b1;
        if (dec_illegal) state_n = S_ERR;
        else begin
          case (dec_class)
            CLS_MEM:   state_n = S_MEMOP;
            CLS_INPUT: state_n = S_INPUT;
            CLS_EXEC:  state_n = S_EXEC;
            CLS_HALT:  state_n = S_HALT;
            default:   state_n = S_ERR;
          endcase
        end
      end
      S_MEMOP: begin
        mem_req  = 1'b1;
        mem_inst = 1'b1;
        mem_wr   = dec_store;
        if (mem_ready) begin
          if (!dec_store) begin
            aload  = 1'b1;
            asel   = dec_asel;
            alu_op = dec_alu_op;
          end
          state_n = S_START;
        end else if (timeout) begin
          state_n = S_ERR;
        end
      end
      S_EXEC: begin
        if (dec_jcond != JC_NONE) begin
          jmp_mux = 1'b1;
          pc_load = jump_taken(dec_jcond, aeq0, apos);
        end else if (dec_class == CLS_EXEC && dec_alu_op != ALU_PASS) begin
          aload  = 1'b1;
          asel   = ASEL_ALU;
          alu_op = dec_alu_op;
        end
        state_n = S_START;
      end
      S_INPUT: begin
        asel  = ASEL_IN;
        aload = 1'b1;
        if (enter) state_n = S_START;
      end
      S_HALT: begin
        halt = 1'b1;
        if (resume) state_n = S_START;
      end
      S_ERR: begin
        halt = 1'b1;
        err  = 1'b1;
      end
      default: state_n = S_START;
    endcase
  end

endmodule
